// File: rtl/race_pkg.sv
// Shared constants for the Race Gear scene generator: colours, screen geometry, state encoding.
// Latency: none; holds constants and pure box-test helpers only.
// Backpressure: none.
package race_pkg;

    localparam logic [2:0] C_BLACK  = 3'b000;
    localparam logic [2:0] C_RED    = 3'b001;
    localparam logic [2:0] C_GREEN  = 3'b010;
    localparam logic [2:0] C_YELLOW = 3'b011;
    localparam logic [2:0] C_BLUE   = 3'b100;
    localparam logic [2:0] C_WHITE  = 3'b111;

    localparam int H_VIS     = 640;
    localparam int V_VIS     = 480;
    localparam int LANE_W    = 80;
    localparam int MAX_SPEED = 6;
    localparam int DASH_L    = 316;
    localparam int DASH_R    = 324;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        CRASH = 2'd2
    } state_t;

    // Half-open box [x, x+w) x [y, y+ht); 11-bit so x+w never wraps.
    function automatic logic in_box(input logic [10:0] h, input logic [10:0] v,
                                    input logic [10:0] x, input logic [10:0] y,
                                    input logic [10:0] w, input logic [10:0] ht);
        return (h >= x) && (h < x + w) && (v >= y) && (v < y + ht);
    endfunction

    function automatic logic boxes_overlap(input logic [10:0] ax, input logic [10:0] ay,
                                           input logic [10:0] bx, input logic [10:0] by,
                                           input logic [10:0] w,  input logic [10:0] ht);
        return (ax < bx + w) && (bx < ax + w) && (ay < by + ht) && (by < ay + ht);
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, taps 8,6,5,4, free-running every clock.
// Latency: new value each clock.
// Backpressure: none; never stalls.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

endmodule

// File: rtl/race_scene_gen.sv
// Race Gear pixel source: frame-level game state plus per-pixel colour for the VGA stage.
// Latency: rgb_out is combinational from hcount/vcount; game state updates once per frame tick.
// Backpressure: none; the timing stage scans continuously.
module race_scene_gen
    import race_pkg::*;
#(
    parameter int         ROAD_LEFT    = 160,
    parameter int         ROAD_RIGHT   = 480,
    parameter int         CAR_W        = 32,
    parameter int         CAR_H        = 48,
    parameter int         PLAYER_Y     = 400,
    parameter int         PLAYER_STEP  = 4,
    parameter int         CRASH_FRAMES = 120,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_start,
    output logic [2:0] rgb_out,
    output logic       crash,
    output logic [7:0] score
);

    localparam logic [9:0] PLAYER_HOME = 10'd304;
    localparam logic [9:0] X_MIN       = 10'(ROAD_LEFT);
    localparam logic [9:0] X_MAX       = 10'(ROAD_RIGHT - CAR_W);
    localparam logic [9:0] LANE0_X     = 10'(ROAD_LEFT + 24);

    state_t     state, state_nxt;
    logic [9:0] player_x, px_nxt, px_mv;
    logic [9:0] enemy_x, ex_nxt, enemy_y, ey_nxt, ey_adv, lane_x;
    logic [9:0] scroll, scroll_nxt;
    logic [2:0] speed, speed_nxt;
    logic [7:0] score_nxt, score_sat;
    logic [6:0] frame_cnt, fcnt_nxt;
    logic [7:0] lfsr;
    logic [5:0] lfsr_unused;
    logic       frame_tick, respawn, hit;

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (lfsr)
    );

    assign lfsr_unused = lfsr[7:2];
    assign frame_tick  = (hcount == 10'd0) && (vcount == 10'(V_VIS));
    assign crash       = (state == CRASH);

    always_comb begin
        state_nxt  = state;
        px_nxt     = player_x;
        ex_nxt     = enemy_x;
        ey_nxt     = enemy_y;
        scroll_nxt = scroll;
        speed_nxt  = speed;
        score_nxt  = score;
        fcnt_nxt   = frame_cnt;

        px_mv = player_x;
        if (btn_left && !btn_right) begin
            px_mv = (player_x <= X_MIN + 10'(PLAYER_STEP)) ? X_MIN : player_x - 10'(PLAYER_STEP);
        end else if (btn_right && !btn_left) begin
            px_mv = (player_x >= X_MAX - 10'(PLAYER_STEP)) ? X_MAX : player_x + 10'(PLAYER_STEP);
        end

        lane_x    = LANE0_X + 10'(lfsr[1:0]) * 10'(LANE_W);
        ey_adv    = enemy_y + 10'(speed);
        respawn   = (ey_adv >= 10'(V_VIS));
        score_sat = (score == 8'hFF) ? score : score + 8'd1;
        hit = boxes_overlap({1'b0, px_mv}, 11'(PLAYER_Y), {1'b0, enemy_x}, {1'b0, ey_adv},
                            11'(CAR_W), 11'(CAR_H));

        case (state)
            IDLE: begin
                if (frame_tick && btn_start) begin
                    state_nxt = PLAY;
                    score_nxt = 8'd0;
                    speed_nxt = 3'd2;
                    ey_nxt    = 10'd0;
                    ex_nxt    = lane_x;
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    px_nxt     = px_mv;
                    scroll_nxt = scroll + 10'(speed);
                    if (respawn) begin
                        // A respawning enemy is off-screen, so it cannot collide this frame.
                        ey_nxt    = 10'd0;
                        ex_nxt    = lane_x;
                        score_nxt = score_sat;
                        if (score != 8'hFF && score_sat[2:0] == 3'd0 && speed < 3'(MAX_SPEED)) begin
                            speed_nxt = speed + 3'd1;
                        end
                    end else begin
                        ey_nxt = ey_adv;
                        if (hit) begin
                            state_nxt = CRASH;
                            fcnt_nxt  = 7'd0;
                        end
                    end
                end
            end
            CRASH: begin
                if (frame_tick) begin
                    if (frame_cnt == 7'(CRASH_FRAMES - 1)) begin
                        state_nxt  = IDLE;
                        px_nxt     = PLAYER_HOME;
                        scroll_nxt = 10'd0;
                        fcnt_nxt   = 7'd0;
                    end else begin
                        fcnt_nxt = frame_cnt + 7'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            player_x  <= PLAYER_HOME;
            enemy_x   <= LANE0_X;
            enemy_y   <= 10'd0;
            speed     <= 3'd2;
            scroll    <= 10'd0;
            score     <= 8'd0;
            frame_cnt <= 7'd0;
        end else begin
            state     <= state_nxt;
            player_x  <= px_nxt;
            enemy_x   <= ex_nxt;
            enemy_y   <= ey_nxt;
            speed     <= speed_nxt;
            scroll    <= scroll_nxt;
            score     <= score_nxt;
            frame_cnt <= fcnt_nxt;
        end
    end

    logic [9:0] lane_row;
    logic       in_player, in_enemy, in_dash, in_road, visible;

    assign lane_row  = vcount - scroll;
    assign visible   = (hcount < 10'(H_VIS)) && (vcount < 10'(V_VIS));
    assign in_player = in_box({1'b0, hcount}, {1'b0, vcount}, {1'b0, player_x}, 11'(PLAYER_Y),
                              11'(CAR_W), 11'(CAR_H));
    assign in_enemy  = in_box({1'b0, hcount}, {1'b0, vcount}, {1'b0, enemy_x}, {1'b0, enemy_y},
                              11'(CAR_W), 11'(CAR_H));
    assign in_dash   = (hcount >= 10'(DASH_L)) && (hcount < 10'(DASH_R)) && !lane_row[5];
    assign in_road   = (hcount >= 10'(ROAD_LEFT)) && (hcount < 10'(ROAD_RIGHT));

    always_comb begin
        rgb_out = C_GREEN;
        if (!visible) begin
            rgb_out = C_BLACK;
        end else if (in_player) begin
            rgb_out = (state == CRASH && frame_cnt[3]) ? C_YELLOW : C_RED;
        end else if (in_enemy && state == PLAY) begin
            rgb_out = C_BLUE;
        end else if (in_dash) begin
            rgb_out = C_WHITE;
        end else if (in_road) begin
            rgb_out = C_BLACK;
        end
    end

endmodule

// File: tb/tb_race_scene_gen.sv
module tb_race_scene_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] hcount = 10'd0;
    logic [9:0] vcount = 10'd0;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_start = 1'b0;
    logic [2:0] rgb_out;
    logic       crash;
    logic [7:0] score;

    int checks = 0;
    int failures = 0;

    localparam int M_IDLE = 0, M_PLAY = 1, M_CRASH = 2;
    int         m_mode, m_px, m_ex, m_ey, m_scroll, m_speed, m_score, m_age;
    logic [7:0] m_lfsr;
    int         pts_h[12], pts_v[12];

    race_scene_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hcount    (hcount),
        .vcount    (vcount),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_start (btn_start),
        .rgb_out   (rgb_out),
        .crash     (crash),
        .score     (score)
    );

    always #20 clk = ~clk;

    initial begin
        #8000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural reference model ----------------
    task automatic model_reset();
        m_mode = M_IDLE; m_px = 304; m_ex = 184; m_ey = 0; m_speed = 2;
        m_scroll = 0; m_score = 0; m_age = 0; m_lfsr = 8'hA5;
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic model_tick(input logic l, input logic r, input logic s);
        int lane;
        lane = 184 + 80 * (int'(m_lfsr) % 4);
        case (m_mode)
            M_IDLE: if (s) begin
                m_mode = M_PLAY; m_score = 0; m_speed = 2; m_ey = 0; m_ex = lane;
            end
            M_PLAY: begin
                if (l && !r) m_px = (m_px - 4 < 160) ? 160 : m_px - 4;
                if (r && !l) m_px = (m_px + 4 > 448) ? 448 : m_px + 4;
                m_scroll = (m_scroll + m_speed) % 1024;
                m_ey = m_ey + m_speed;
                if (m_ey >= 480) begin
                    m_ey = 0; m_ex = lane;
                    if (m_score < 255) begin
                        m_score++;
                        if (m_score % 8 == 0 && m_speed < 6) m_speed++;
                    end
                end else if (m_px < m_ex + 32 && m_ex < m_px + 32 && 400 < m_ey + 48 && m_ey < 448) begin
                    m_mode = M_CRASH; m_age = 0;
                end
            end
            default: begin
                m_age++;
                if (m_age == 120) begin
                    m_mode = M_IDLE; m_px = 304; m_scroll = 0;
                end
            end
        endcase
    endtask

    function automatic logic [2:0] model_pix(input int h, input int v);
        if (h >= 640 || v >= 480) return 3'b000;
        if (h >= m_px && h < m_px + 32 && v >= 400 && v < 448)
            return (m_mode == M_CRASH && (m_age / 8) % 2 == 1) ? 3'b011 : 3'b001;
        if (m_mode == M_PLAY && h >= m_ex && h < m_ex + 32 && v >= m_ey && v < m_ey + 48) return 3'b100;
        if (h >= 316 && h < 324 && (((v - m_scroll + 1024) % 1024) / 32) % 2 == 0) return 3'b111;
        if (h >= 160 && h < 480) return 3'b000;
        return 3'b010;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        logic tick;
        tick = (hcount == 10'd0) && (vcount == 10'd480);
        @(posedge clk);
        if (rst_n) begin
            if (tick) model_tick(btn_left, btn_right, btn_start);
            m_lfsr = lfsr_next(m_lfsr);
        end
        @(negedge clk);
    endtask

    task automatic run_frame(input logic l, input logic r, input logic s);
        btn_left = l; btn_right = r; btn_start = s;
        hcount = 10'd0; vcount = 10'd480;
        step();
        btn_left = 1'b0; btn_right = 1'b0; btn_start = 1'b0;
    endtask

    task automatic set_pixel(input int h, input int v);
        hcount = 10'(h); vcount = 10'(v);
        #1;
    endtask

    task automatic fill_points();
        pts_h[0] = m_px;      pts_v[0] = 400;
        pts_h[1] = m_px + 31; pts_v[1] = 447;
        pts_h[2] = m_px - 1;  pts_v[2] = 420;
        pts_h[3] = m_px + 32; pts_v[3] = 420;
        pts_h[4] = m_px + 10; pts_v[4] = 399;
        pts_h[5] = m_px + 10; pts_v[5] = 448;
        pts_h[6] = m_ex;      pts_v[6] = m_ey;
        pts_h[7] = m_ex + 31; pts_v[7] = m_ey + 47;
        pts_h[8] = m_ex - 1;  pts_v[8] = m_ey + 10;
        pts_h[9] = m_ex + 32; pts_v[9] = m_ey + 10;
        for (int k = 10; k < 12; k++) begin
            pts_h[k] = $urandom_range(1, 799);
            pts_v[k] = $urandom_range(0, 524);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int         hs[4] = '{100, 200, 310, 700};
        int         vs[4] = '{100, 10, 410, 100};
        logic [2:0] ex[4] = '{3'b010, 3'b000, 3'b001, 3'b000};
        rst_n = 1'b0;
        model_reset();
        step(); step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_pixel(hs[k], vs[k]);
            checks++;
            if (rgb_out !== ex[k]) begin
                failures++;
                $display("FAIL reset_pix (%0d,%0d) rgb=%b expected=%b", hs[k], vs[k], rgb_out, ex[k]);
            end
            step();
        end
        checks++;
        if ({crash, score} !== 9'd0) begin
            failures++;
            $display("FAIL reset_status crash=%b score=%0d expected crash=0 score=0", crash, score);
        end
    endtask

    task automatic test_steer();
        run_frame(1'b0, 1'b0, 1'b1);
        for (int seg = 0; seg < 3; seg++) begin
            int n = (seg == 0) ? 36 : (seg == 1) ? 14 : 10;
            for (int i = 0; i < n; i++) begin
                run_frame(1'b1, seg == 2, 1'b0);
                checks++;
                if ({crash, score} !== {m_mode == M_CRASH, 8'(m_score)}) begin
                    failures++;
                    $display("FAIL steer_status crash=%b score=%0d expected crash=%b score=%0d",
                             crash, score, m_mode == M_CRASH, m_score);
                end
            end
            fill_points();
            for (int k = 0; k < 12; k++) begin
                set_pixel(pts_h[k], pts_v[k]);
                checks++;
                if (rgb_out !== model_pix(pts_h[k], pts_v[k])) begin
                    failures++;
                    $display("FAIL steer_pix (%0d,%0d) rgb=%b expected=%b",
                             pts_h[k], pts_v[k], rgb_out, model_pix(pts_h[k], pts_v[k]));
                end
                step();
            end
        end
    endtask

    task automatic test_enemy_descent();
        for (int i = 0; i < 332; i++) begin
            run_frame(1'b0, i < 72, 1'b0);
            checks++;
            if ({crash, score} !== {m_mode == M_CRASH, 8'(m_score)}) begin
                failures++;
                $display("FAIL descent_status frame=%0d crash=%b score=%0d expected crash=%b score=%0d",
                         i, crash, score, m_mode == M_CRASH, m_score);
            end
            if (i % 40 == 39) begin
                fill_points();
                for (int k = 0; k < 12; k++) begin
                    set_pixel(pts_h[k], pts_v[k]);
                    checks++;
                    if (rgb_out !== model_pix(pts_h[k], pts_v[k])) begin
                        failures++;
                        $display("FAIL descent_pix (%0d,%0d) rgb=%b expected=%b",
                                 pts_h[k], pts_v[k], rgb_out, model_pix(pts_h[k], pts_v[k]));
                    end
                    step();
                end
            end
        end
    endtask

    task automatic test_crash();
        int n = 0;
        while (m_mode != M_PLAY && n < 400) begin
            run_frame(1'b0, 1'b0, m_mode == M_IDLE);
            n++;
        end
        n = 0;
        while (m_mode == M_PLAY && n < 3000) begin
            run_frame(m_px > m_ex, m_px < m_ex, 1'b0);
            checks++;
            if ({crash, score} !== {m_mode == M_CRASH, 8'(m_score)}) begin
                failures++;
                $display("FAIL crash_entry crash=%b score=%0d expected crash=%b score=%0d",
                         crash, score, m_mode == M_CRASH, m_score);
            end
            n++;
        end
        checks++;
        if (m_mode != M_CRASH) begin
            failures++;
            $display("FAIL crash_timeout no collision reached within %0d frames, required a crash", n);
        end
        for (int i = 0; i < 120; i++) begin
            run_frame(1'b0, 1'b0, i >= 40 && i < 60);
            checks++;
            if ({crash, score} !== {m_mode == M_CRASH, 8'(m_score)}) begin
                failures++;
                $display("FAIL crash_status frame=%0d crash=%b score=%0d expected crash=%b score=%0d",
                         i, crash, score, m_mode == M_CRASH, m_score);
            end
            set_pixel(m_px + 5, 420);
            checks++;
            if (rgb_out !== model_pix(m_px + 5, 420)) begin
                failures++;
                $display("FAIL crash_flash frame=%0d rgb=%b expected=%b", i, rgb_out, model_pix(m_px + 5, 420));
            end
            step();
        end
        fill_points();
        for (int k = 0; k < 12; k++) begin
            set_pixel(pts_h[k], pts_v[k]);
            checks++;
            if (rgb_out !== model_pix(pts_h[k], pts_v[k])) begin
                failures++;
                $display("FAIL after_crash_pix (%0d,%0d) rgb=%b expected=%b",
                         pts_h[k], pts_v[k], rgb_out, model_pix(pts_h[k], pts_v[k]));
            end
            step();
        end
    endtask

    task automatic test_speed_ramp();
        int n = 0;
        int prev;
        run_frame(1'b0, 1'b0, 1'b1);
        while ((m_score < 255 || n < 30000 - 200) && n < 30000 && m_mode == M_PLAY) begin
            prev = m_score;
            run_frame(1'b0, 1'b0, 1'b0);
            n++;
            checks++;
            if ({crash, score} !== {m_mode == M_CRASH, 8'(m_score)}) begin
                failures++;
                $display("FAIL ramp_status frame=%0d crash=%b score=%0d expected crash=%b score=%0d",
                         n, crash, score, m_mode == M_CRASH, m_score);
            end
            if (m_score != prev && (m_score % 8 == 0 || m_score == 255)) begin
                fill_points();
                for (int k = 0; k < 12; k++) begin
                    set_pixel(pts_h[k], pts_v[k]);
                    checks++;
                    if (rgb_out !== model_pix(pts_h[k], pts_v[k])) begin
                        failures++;
                        $display("FAIL ramp_pix score=%0d (%0d,%0d) rgb=%b expected=%b", m_score,
                                 pts_h[k], pts_v[k], rgb_out, model_pix(pts_h[k], pts_v[k]));
                    end
                    step();
                end
            end
            if (m_score == 255 && prev == 255 && m_ey == 0) break;
        end
        checks++;
        if (score !== 8'd255) begin
            failures++;
            $display("FAIL score_saturate score=%0d expected=255", score);
        end
    endtask

    task automatic test_reset_midframe();
        set_pixel(300, 200);
        step();
        #5;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({crash, score, rgb_out} !== {1'b0, 8'd0, 3'b000}) begin
            failures++;
            $display("FAIL midreset_async crash=%b score=%0d rgb=%b expected crash=0 score=0 rgb=000",
                     crash, score, rgb_out);
        end
        set_pixel(310, 410);
        checks++;
        if (rgb_out !== 3'b001) begin
            failures++;
            $display("FAIL midreset_player rgb=%b expected=001", rgb_out);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_frame(i[0], 1'b0, 1'b0);
            checks++;
            if ({crash, score} !== {m_mode == M_CRASH, 8'(m_score)}) begin
                failures++;
                $display("FAIL midreset_hold crash=%b score=%0d expected crash=%b score=%0d",
                         crash, score, m_mode == M_CRASH, m_score);
            end
        end
        run_frame(1'b0, 1'b0, 1'b1);
        run_frame(1'b0, 1'b1, 1'b0);
        fill_points();
        for (int k = 0; k < 12; k++) begin
            set_pixel(pts_h[k], pts_v[k]);
            checks++;
            if (rgb_out !== model_pix(pts_h[k], pts_v[k])) begin
                failures++;
                $display("FAIL midreset_pix (%0d,%0d) rgb=%b expected=%b",
                         pts_h[k], pts_v[k], rgb_out, model_pix(pts_h[k], pts_v[k]));
            end
            step();
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_steer();
        test_enemy_descent();
        test_crash();
        test_speed_ramp();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/race_scene_gen.md
Name: race_scene_gen

Overview:
- Pixel-colour source for the Race Gear display path. Sits directly upstream of the VGA timing/output stage.
- Consumes that stage's hor_count/ver_count and returns the 3-bit colour it samples as rgb_in.
- Holds all frame-level game state: player car, one enemy car, scrolling lane markings, score, crash sequence.
- Game state updates once per frame, during vertical blanking.

Parameters:
- ROAD_LEFT, 160, leftmost road pixel column.
- ROAD_RIGHT, 480, first grass column right of the road.
- CAR_W, 32, car width in pixels.
- CAR_H, 48, car height in pixels.
- PLAYER_Y, 400, fixed top row of the player car.
- PLAYER_STEP, 4, player x pixels moved per frame.
- CRASH_FRAMES, 120, frames spent in CRASH state.
- LFSR_SEED, 8'hA5, reset value of the lane LFSR (must be nonzero).

Ports:
- clk  in  1  pixel clock (25 MHz); same clock as the timing stage.
- rst_n  in  1  asynchronous active-low reset.
- hcount  in  10  current column from the timing stage.
- vcount  in  10  current row from the timing stage.
- btn_left  in  1  move left, level, pre-synchronised.
- btn_right  in  1  move right, level, pre-synchronised.
- btn_start  in  1  start game, level, pre-synchronised.
- rgb_out  out  3  colour: bit0 red, bit1 green, bit2 blue; drives the timing stage's rgb_in.
- crash  out  1  high while in CRASH.
- score  out  8  enemies passed, saturating.

Behaviour:
Interface and reset:
- One clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, player_x=304, enemy_x=184, enemy_y=0, speed=2, scroll=0, crash=0, score=0, frame counter=0, LFSR=LFSR_SEED.
- rgb_out is combinational from hcount/vcount and registered state, so it is valid immediately after reset.

Frame tick:
- frame_tick = (hcount==0 && vcount==480); exactly one clk per frame.
- All game-state registers change only on frame_tick. Exceptions: the LFSR, and reset.

Pixel colour (zero latency, priority high to low):
- Outside 640x480 (hcount>=640 or vcount>=480): 3'b000.
- Player car box: 3'b001 (red). In CRASH, alternates with 3'b011 (yellow) on frame counter bit 3.
- Enemy car box, PLAY only: 3'b100 (blue).
- Lane dash, hcount in [316,324) and ((vcount - scroll) bit5 == 0): 3'b111.
- Road, hcount in [ROAD_LEFT,ROAD_RIGHT): 3'b000.
- Otherwise: grass 3'b010.
- Car box = x <= hcount < x+CAR_W and y <= vcount < y+CAR_H.

State machine:
- IDLE
  - Static scene, no enemy drawn.
  - btn_start on frame_tick: score=0, speed=2, enemy_y=0, enemy_x from LFSR; go to PLAY.
- PLAY, on each frame_tick:
  - Move player:
    - btn_left alone: player_x -= PLAYER_STEP.
    - btn_right alone: player_x += PLAYER_STEP.
    - Both buttons or neither: no move.
    - Clamp to [ROAD_LEFT, ROAD_RIGHT-CAR_W] = [160,448]. Never wrap.
  - scroll += speed, modulo 1024.
  - enemy_y += speed.
  - Respawn: if the new enemy_y >= 480:
    - enemy_y=0; enemy_x = ROAD_LEFT + lfsr[1:0]*80 + 24.
    - score+1, saturating at 255.
    - When the new score is a multiple of 8: speed+1, capped at 6.
  - Collision: rectangle overlap of player and enemy, evaluated on the updated positions.
    - A respawn tick never reports a collision.
    - On overlap: go to CRASH, crash=1, frame counter=0.
- CRASH
  - Frame counter increments each frame_tick.
  - When the counter reaches CRASH_FRAMES-1: go to IDLE, crash=0, player_x=304, scroll=0. Score is held.
  - btn_start is ignored in CRASH.

LFSR:
- 8-bit Fibonacci, taps 8,6,5,4.
- Advances every clk, so button timing randomises the lane.

Reset mid-frame:
- Immediate return to the reset values above; no partial update on the next frame_tick.

Decomposition:
- Shared package race_pkg:
  - Colour constants (C_BLACK, C_RED, C_GREEN, C_YELLOW, C_BLUE, C_WHITE).
  - State encoding (IDLE=2'd0, PLAY=2'd1, CRASH=2'd2).
  - Screen constants H_VIS=640, V_VIS=480, LANE_W=80, MAX_SPEED=6.
- One sub-module, lfsr8: clk, rst_n, seed parameter, 8-bit output.
- Rectangle hit tests and colour mux remain in race_scene_gen.

Test Plan:
1. Reset released, free-running counters, no buttons:
   - hcount=100,vcount=100 gives 3'b010.
   - hcount=200,vcount=10 gives 3'b000.
   - hcount=310,vcount=410 gives 3'b001.
   - hcount=700 gives 3'b000.
   - crash=0, score=0.
2. btn_start held one frame, then btn_left held 50 frames:
   - player_x is 160 after 36 frames and stays 160.
   - Both buttons held: player_x unchanged.
3. PLAY, player at 448, no input:
   - Enemy advances 2 px/frame.
   - After 240 frames enemy_y wraps to 0, score=1.
   - enemy_x is in {184,264,344,424}.
4. Force enemy lane equal to player column, no input:
   - crash rises on the frame of first overlap.
   - rgb_out over the player toggles 3'b001/3'b011 every 8 frames.
   - After 120 frames: crash=0, state IDLE, score held.
5. Reach score 8 and 48 (force via many respawns):
   - speed becomes 3 at score 8 and 6 at score 32.
   - speed stays 6 after score 48.
   - score saturates at 255.
6. Assert rst_n low mid-line in PLAY (hcount=300,vcount=200):
   - All outputs take their reset values asynchronously.
   - No update on the following frame_tick until btn_start.
